// File: rtl/udp_tx_pkg.sv
// ---------------------------------------------------------------------------
// udp_tx_pkg
// Shared definitions for the UDP application TX responder:
//   - ingress state encoding (IDLE / ARP_WAIT / GRANT / RECV)
//   - beat field widths and the packed layout of a buffered payload beat
//   - popcount8 helper used to turn a keep mask into a byte count
// ---------------------------------------------------------------------------
package udp_tx_pkg;

    localparam int DATA_W      = 64;
    localparam int KEEP_W      = 8;
    localparam int LEN_W       = 16;
    localparam int BEAT_W      = DATA_W + KEEP_W + 1;
    localparam int LEN_Q_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARP_WAIT = 2'd1,
        GRANT    = 2'd2,
        RECV     = 2'd3
    } state_t;

    // Number of set bits in an 8-bit keep mask (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/udp_tx_sync_fifo.sv
// ---------------------------------------------------------------------------
// udp_tx_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rd_data whenever count is non-zero; rd_en consumes it. Writes to a full
// FIFO and reads from an empty FIFO are ignored. Simultaneous read and write
// leave the occupancy unchanged.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (clears pointers and count)
//   wr_en    in   push wr_data
//   wr_data  in   WIDTH bits
//   rd_en    in   pop head entry
//   rd_data  out  head entry (valid while count != 0)
//   count    out  current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module udp_tx_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != CW'(DEPTH));
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/udp_app_tx_responder.sv
// ---------------------------------------------------------------------------
// udp_app_tx_responder
// Stack-side responder for the UDP application TX handshake. Resolves the
// destination MAC via ARP (timeout + retry), grants the application a send
// slot, buffers the payload beats and forwards complete packets downstream
// as a valid/ready stream together with the packet length.
//
// Optional feature macro: UDP_TX_LEN_CHECK_EN
//   defined   : the received byte count is compared with the requested
//               length; a mismatch sets len_error (sticky) and the counted
//               value is forwarded as out_length.
//   undefined : len_error is 0 and app_tx_data_length is forwarded as-is.
//
// Ports:
//   udp_core_clk        in   core clock
//   core_reset_n        in   asynchronous active-low reset
//   udp_tx_ready        out  responder can accept a request
//   app_tx_request      in   level request from the application
//   app_tx_ack          out  one-cycle grant pulse
//   app_tx_data_valid   in   payload beat valid
//   app_tx_data         in   64-bit payload beat, byte 0 in [7:0]
//   app_tx_data_keep    in   byte enables, contiguous from bit 0
//   app_tx_data_last    in   final beat of the packet
//   app_tx_data_length  in   UDP payload bytes, sampled with the ack
//   dst_ip_unreachable  out  one-cycle pulse, ARP retries exhausted
//   arp_query           out  one-cycle ARP lookup strobe
//   arp_hit             in   ARP resolved (level)
//   out_valid/out_data/out_keep/out_last  out  downstream beat
//   out_length          out  packet length, stable while out_valid
//   out_ready           in   downstream accepts the beat
//   len_error           out  sticky length mismatch
// ---------------------------------------------------------------------------
module udp_app_tx_responder
    import udp_tx_pkg::*;
#(
    parameter int FIFO_DEPTH    = 512,
    parameter int MAX_PKT_BEATS = 190,
    parameter int ARP_TIMEOUT   = 20_000_000,
    parameter int ARP_RETRY     = 2
) (
    input  logic              udp_core_clk,
    input  logic              core_reset_n,
    output logic              udp_tx_ready,
    input  logic              app_tx_request,
    output logic              app_tx_ack,
    input  logic              app_tx_data_valid,
    input  logic [DATA_W-1:0] app_tx_data,
    input  logic [KEEP_W-1:0] app_tx_data_keep,
    input  logic              app_tx_data_last,
    input  logic [LEN_W-1:0]  app_tx_data_length,
    output logic              dst_ip_unreachable,
    output logic              arp_query,
    input  logic              arp_hit,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic [LEN_W-1:0]  out_length,
    input  logic              out_ready,
    output logic              len_error
);

    localparam int              PAY_CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              LEN_CW       = $clog2(LEN_Q_DEPTH) + 1;
    localparam logic [31:0]     TIMEOUT_LAST = 32'(ARP_TIMEOUT - 1);
    localparam logic [7:0]      RETRY_LIMIT  = 8'(ARP_RETRY);
    localparam logic [PAY_CW-1:0] PAY_DEPTH_C = PAY_CW'(FIFO_DEPTH);
    localparam logic [PAY_CW-1:0] MAX_BEATS_C = PAY_CW'(MAX_PKT_BEATS);
    localparam logic [LEN_CW-1:0] LEN_DEPTH_C = LEN_CW'(LEN_Q_DEPTH);

    state_t              state;
    state_t              next_state;
    logic [31:0]         arp_timer;
    logic [31:0]         arp_timer_d;
    logic [7:0]          retry_cnt;
    logic [7:0]          retry_cnt_d;
    logic                arp_query_d;
    logic                unreach_d;
    logic                ready_d;
    logic [LEN_W-1:0]    len_latched;

    logic                pay_wr;
    logic                pay_rd;
    logic [BEAT_W-1:0]   pay_wdata;
    logic [BEAT_W-1:0]   pay_rdata;
    logic [PAY_CW-1:0]   pay_count;
    logic [PAY_CW-1:0]   pay_occ_next;
    logic [PAY_CW-1:0]   pay_free_next;

    logic                len_wr;
    logic                len_rd;
    logic [LEN_W-1:0]    len_wdata;
    logic [LEN_W-1:0]    len_rdata;
    logic [LEN_CW-1:0]   len_count;

    // Ingress writes: only beats inside RECV are buffered. The length entry is
    // pushed together with the last beat, so a non-empty length queue always
    // means at least one complete packet sits in the payload FIFO.
    assign pay_wr    = (state == RECV) && app_tx_data_valid;
    assign pay_wdata = {app_tx_data, app_tx_data_keep, app_tx_data_last};
    assign len_wr    = pay_wr && app_tx_data_last;

    // Occupancy after this cycle's accepted write; reads are ignored so the
    // free-space estimate errs on the safe side.
    assign pay_occ_next  = pay_count + PAY_CW'(pay_wr && (pay_count != PAY_DEPTH_C));
    assign pay_free_next = PAY_DEPTH_C - pay_occ_next;

    // Next-state logic for the ingress FSM plus the ARP timer/retry and the
    // registered strobes. arp_hit is tested before the timer so that a hit on
    // the expiry cycle still leads to a grant.
    always_comb begin
        next_state  = state;
        arp_timer_d = arp_timer;
        retry_cnt_d = retry_cnt;
        arp_query_d = 1'b0;
        unreach_d   = 1'b0;
        case (state)
            IDLE: begin
                if (app_tx_request && udp_tx_ready) begin
                    next_state  = ARP_WAIT;
                    arp_query_d = 1'b1;
                    arp_timer_d = '0;
                    retry_cnt_d = '0;
                end
            end
            ARP_WAIT: begin
                if (arp_hit) begin
                    next_state = GRANT;
                end else if (arp_timer == TIMEOUT_LAST) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        arp_query_d = 1'b1;
                        arp_timer_d = '0;
                        retry_cnt_d = retry_cnt + 8'd1;
                    end else begin
                        unreach_d  = 1'b1;
                        next_state = IDLE;
                    end
                end else begin
                    arp_timer_d = arp_timer + 32'd1;
                end
            end
            GRANT: begin
                next_state = RECV;
            end
            RECV: begin
                if (app_tx_data_valid && app_tx_data_last) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // Ready is offered only from IDLE with room for a maximum-size packet
        // and a free slot for its length entry.
        ready_d = (next_state == IDLE) && (pay_free_next >= MAX_BEATS_C) &&
                  (len_count != LEN_DEPTH_C);
    end

    // State register and registered ingress outputs.
    always_ff @(posedge udp_core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            state              <= IDLE;
            arp_timer          <= '0;
            retry_cnt          <= '0;
            arp_query          <= 1'b0;
            dst_ip_unreachable <= 1'b0;
            udp_tx_ready       <= 1'b0;
            len_latched        <= '0;
        end else begin
            state              <= next_state;
            arp_timer          <= arp_timer_d;
            retry_cnt          <= retry_cnt_d;
            arp_query          <= arp_query_d;
            dst_ip_unreachable <= unreach_d;
            udp_tx_ready       <= ready_d;
            if (state == GRANT) begin
                len_latched <= app_tx_data_length;
            end
        end
    end

    assign app_tx_ack = (state == GRANT);

`ifdef UDP_TX_LEN_CHECK_EN
    logic [LEN_W-1:0] byte_cnt;
    logic [LEN_W-1:0] byte_total;

    // Count including the beat currently being written.
    assign byte_total = byte_cnt + {12'd0, popcount8(app_tx_data_keep)};
    assign len_wdata  = byte_total;

    // Byte counter restarts at the grant; the error flag only clears on reset.
    always_ff @(posedge udp_core_clk or negedge core_reset_n) begin
        if (!core_reset_n) begin
            byte_cnt  <= '0;
            len_error <= 1'b0;
        end else begin
            if (state == GRANT) begin
                byte_cnt <= '0;
            end else if (pay_wr) begin
                byte_cnt <= byte_total;
            end
            if (len_wr && (byte_total != len_latched)) begin
                len_error <= 1'b1;
            end
        end
    end
`else
    assign len_wdata = len_latched;
    assign len_error = 1'b0;
`endif

    // Egress: store-and-forward, a beat is offered only when its packet is
    // complete. Outputs are forced to zero when nothing is offered so the
    // unreset FIFO storage never leaks onto the bus.
    assign out_valid  = (len_count != '0) && (pay_count != '0);
    assign pay_rd     = out_valid && out_ready;
    assign len_rd     = pay_rd && pay_rdata[0];
    assign out_data   = out_valid ? pay_rdata[BEAT_W-1:KEEP_W+1] : '0;
    assign out_keep   = out_valid ? pay_rdata[KEEP_W:1] : '0;
    assign out_last   = out_valid && pay_rdata[0];
    assign out_length = out_valid ? len_rdata : '0;

    udp_tx_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_payload_fifo (
        .clk     (udp_core_clk),
        .rst_n   (core_reset_n),
        .wr_en   (pay_wr),
        .wr_data (pay_wdata),
        .rd_en   (pay_rd),
        .rd_data (pay_rdata),
        .count   (pay_count)
    );

    udp_tx_sync_fifo #(
        .WIDTH (LEN_W),
        .DEPTH (LEN_Q_DEPTH)
    ) u_length_queue (
        .clk     (udp_core_clk),
        .rst_n   (core_reset_n),
        .wr_en   (len_wr),
        .wr_data (len_wdata),
        .rd_en   (len_rd),
        .rd_data (len_rdata),
        .count   (len_count)
    );

endmodule

// File: tb/tb_udp_app_tx_responder.sv
// ---------------------------------------------------------------------------
// tb_udp_app_tx_responder
// Self-checking bench for udp_app_tx_responder. Expected beats are queued
// when a packet is driven and compared when the DUT presents them downstream.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_udp_app_tx_responder;

    localparam int FIFO_DEPTH    = 16;
    localparam int MAX_PKT_BEATS = 8;
    localparam int ARP_TIMEOUT   = 100;
    localparam int ARP_RETRY     = 2;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] len;
    } beat_t;

    logic        udp_core_clk = 1'b0;
    logic        core_reset_n = 1'b0;
    logic        udp_tx_ready;
    logic        app_tx_request = 1'b0;
    logic        app_tx_ack;
    logic        app_tx_data_valid = 1'b0;
    logic [63:0] app_tx_data = '0;
    logic [7:0]  app_tx_data_keep = '0;
    logic        app_tx_data_last = 1'b0;
    logic [15:0] app_tx_data_length = '0;
    logic        dst_ip_unreachable;
    logic        arp_query;
    logic        arp_hit = 1'b1;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;
    logic [15:0] out_length;
    logic        out_ready = 1'b1;
    logic        len_error;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    beat_t exp_q[$];
    int    qcyc[$];

    udp_app_tx_responder #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .MAX_PKT_BEATS (MAX_PKT_BEATS),
        .ARP_TIMEOUT   (ARP_TIMEOUT),
        .ARP_RETRY     (ARP_RETRY)
    ) dut (
        .udp_core_clk       (udp_core_clk),
        .core_reset_n       (core_reset_n),
        .udp_tx_ready       (udp_tx_ready),
        .app_tx_request     (app_tx_request),
        .app_tx_ack         (app_tx_ack),
        .app_tx_data_valid  (app_tx_data_valid),
        .app_tx_data        (app_tx_data),
        .app_tx_data_keep   (app_tx_data_keep),
        .app_tx_data_last   (app_tx_data_last),
        .app_tx_data_length (app_tx_data_length),
        .dst_ip_unreachable (dst_ip_unreachable),
        .arp_query          (arp_query),
        .arp_hit            (arp_hit),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_keep           (out_keep),
        .out_last           (out_last),
        .out_length         (out_length),
        .out_ready          (out_ready),
        .len_error          (len_error)
    );

    always #5 udp_core_clk = ~udp_core_clk;

    always @(posedge udp_core_clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Scoreboard: every accepted downstream beat is matched against the queue.
    always @(negedge udp_core_clk) begin : monitor
        beat_t e;
        if (core_reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_data",   out_data,        e.data);
                checkOutput("out_keep",   64'(out_keep),   64'(e.keep));
                checkOutput("out_last",   64'(out_last),   64'(e.last));
                checkOutput("out_length", 64'(out_length), 64'(e.len));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge udp_core_clk);
        while (!udp_tx_ready && n < 2000) begin
            @(negedge udp_core_clk);
            n++;
        end
        if (!udp_tx_ready) checkOutput("ready_timeout", 64'(udp_tx_ready), 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge udp_core_clk);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Drives one packet of nbytes with length field len_field. If nsend > 0,
    // only the first nsend beats are driven and reset is asserted afterwards.
    task automatic applyStimulus(input int nbytes, input int len_field, input int nsend);
        int    nbeats;
        int    limit;
        int    req_cyc;
        int    q_cyc;
        int    a_cyc;
        int    n;
        int    rem;
        int    exp_len;
        beat_t b;
        beat_t pend[$];
        nbeats = (nbytes + 7) / 8;
        limit  = (nsend > 0) ? nsend : nbeats;
`ifdef UDP_TX_LEN_CHECK_EN
        exp_len = nbytes;
`else
        exp_len = len_field;
`endif
        q_cyc = -1;
        a_cyc = -1;
        wait_ready();
        app_tx_request     = 1'b1;
        app_tx_data_length = 16'(len_field);
        req_cyc            = cyc;
        n = 0;
        while (a_cyc < 0 && n < 1000) begin
            @(negedge udp_core_clk);
            n++;
            if (arp_query && q_cyc < 0) begin
                q_cyc = cyc;
                checkOutput("ready_drop", 64'(udp_tx_ready), 64'd0);
            end
            if (app_tx_ack) a_cyc = cyc;
        end
        if (a_cyc < 0) begin
            checkOutput("ack_timeout", 64'(app_tx_ack), 64'd1);
            app_tx_request = 1'b0;
            return;
        end
        checkOutput("query_latency", 64'(q_cyc - req_cyc), 64'd1);
        checkOutput("ack_latency",   64'(a_cyc - q_cyc),   64'd1);
        @(negedge udp_core_clk);
        app_tx_request = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                app_tx_data_valid = 1'b0;
                @(negedge udp_core_clk);
            end
            rem    = nbytes - 8 * i;
            b.keep = (rem >= 8) ? 8'hff : 8'((1 << rem) - 1);
            b.data = {$urandom, $urandom};
            b.last = (i == nbeats - 1);
            b.len  = 16'(exp_len);
            app_tx_data_valid = 1'b1;
            app_tx_data       = b.data;
            app_tx_data_keep  = b.keep;
            app_tx_data_last  = b.last;
            pend.push_back(b);
            @(negedge udp_core_clk);
        end
        app_tx_data_valid = 1'b0;
        app_tx_data_last  = 1'b0;
        if (nsend > 0) begin
            core_reset_n = 1'b0;
        end else begin
            foreach (pend[k]) exp_q.push_back(pend[k]);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int un_cyc;
        int un_ready;
        int ack_cnt;
        int req_cyc;
        int seen;

        // Reset state.
        repeat (3) @(negedge udp_core_clk);
        checkOutput("rst_ready",  64'(udp_tx_ready),       64'd0);
        checkOutput("rst_valid",  64'(out_valid),          64'd0);
        checkOutput("rst_ack",    64'(app_tx_ack),         64'd0);
        checkOutput("rst_query",  64'(arp_query),          64'd0);
        checkOutput("rst_unreach",64'(dst_ip_unreachable), 64'd0);
        checkOutput("rst_lenerr", 64'(len_error),          64'd0);
        checkOutput("rst_data",   out_data,                64'd0);
        checkOutput("rst_length", 64'(out_length),         64'd0);
        core_reset_n = 1'b1;
        @(negedge udp_core_clk);
        checkOutput("ready_after_release", 64'(udp_tx_ready), 64'd1);

        // 20-byte packet: keep ff, ff, 0f.
        $display("[TB] 20-byte packet");
        applyStimulus(20, 20, 0);
        wait_drain();

        // ARP never resolves.
        $display("[TB] ARP retry and unreachable");
        arp_hit = 1'b0;
        un_cyc = -1; un_ready = 0; ack_cnt = 0;
        wait_ready();
        app_tx_request     = 1'b1;
        app_tx_data_length = 16'd32;
        req_cyc            = cyc;
        for (int i = 0; i < 400; i++) begin
            @(negedge udp_core_clk);
            if (arp_query) begin
                qcyc.push_back(cyc);
                app_tx_request = 1'b0;
            end
            if (dst_ip_unreachable) begin
                un_cyc   = cyc;
                un_ready = int'(udp_tx_ready);
            end
            if (app_tx_ack) ack_cnt++;
        end
        checkOutput("arp_query_count", 64'(qcyc.size()), 64'd3);
        if (qcyc.size() >= 3) begin
            checkOutput("arp_query0", 64'(qcyc[0] - req_cyc), 64'd1);
            checkOutput("arp_query1", 64'(qcyc[1] - qcyc[0]), 64'd100);
            checkOutput("arp_query2", 64'(qcyc[2] - qcyc[0]), 64'd200);
            checkOutput("unreach_time", 64'(un_cyc - qcyc[0]), 64'd300);
        end
        checkOutput("unreach_ready", 64'(un_ready), 64'd1);
        checkOutput("unreach_no_ack", 64'(ack_cnt), 64'd0);
        arp_hit = 1'b1;

        // Downstream stall during a 10-beat packet.
        $display("[TB] downstream stall");
        out_ready = 1'b0;
        applyStimulus(80, 80, 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge udp_core_clk);
            if (i % 10 == 0 && exp_q.size() > 0) begin
                checkOutput("stall_valid", 64'(out_valid), 64'd1);
                checkOutput("stall_data",  out_data, exp_q[0].data);
                checkOutput("stall_ready", 64'(udp_tx_ready), 64'd0);
            end
        end
        out_ready = 1'b1;
        wait_drain();

        // Back-to-back packets of 8, 64 and 1 bytes.
        $display("[TB] back-to-back packets");
        applyStimulus(8, 8, 0);
        applyStimulus(64, 64, 0);
        applyStimulus(1, 1, 0);
        wait_drain();

        // Reset after 2 of 5 beats.
        $display("[TB] reset mid-packet");
        applyStimulus(40, 40, 2);
        @(negedge udp_core_clk);
        checkOutput("midrst_valid", 64'(out_valid),    64'd0);
        checkOutput("midrst_ready", 64'(udp_tx_ready), 64'd0);
        checkOutput("midrst_ack",   64'(app_tx_ack),   64'd0);
        checkOutput("midrst_query", 64'(arp_query),    64'd0);
        checkOutput("midrst_keep",  64'(out_keep),     64'd0);
        repeat (2) @(negedge udp_core_clk);
        core_reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge udp_core_clk);
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_egress", 64'(seen), 64'd0);
        applyStimulus(24, 24, 0);
        wait_drain();

        // Length mismatch: header says 16, payload carries 12 bytes.
        $display("[TB] length mismatch");
        checkOutput("lenerr_before", 64'(len_error), 64'd0);
        applyStimulus(12, 16, 0);
        wait_drain();
`ifdef UDP_TX_LEN_CHECK_EN
        checkOutput("lenerr_after", 64'(len_error), 64'd1);
`else
        checkOutput("lenerr_after", 64'(len_error), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
